// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the LemonPC instruction fetch stage
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        HALT
    } state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - program counter register with hold / +4 / redirect next-PC selection
module ifu_pc
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    // Redirect targets are word aligned by dropping the two low bits.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target & ALIGN_MASK;
        end else if (advance) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage; optional ebreak halt under IFU_EBREAK_HALT_EN
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted
);

    state_t          state;
    logic            drop;
    logic [XLEN-1:0] pc;
    logic            inst_fire;
    logic            halt_take;
    logic            redirect_live;
    logic            pc_load;
    logic            pc_advance;

    assign inst_fire     = (state == OUT) && inst_ready;
    assign redirect_live = redirect_valid && ((state == REQ) || (state == WAIT) || (state == OUT));

`ifdef IFU_EBREAK_HALT_EN
    assign halt_take = inst_fire && (inst == EBREAK_INST);
`else
    assign halt_take = 1'b0;
`endif

    // Halting on ebreak takes precedence over a coincident redirect.
    assign pc_load    = redirect_live && !halt_take;
    assign pc_advance = inst_fire && !redirect_valid && !halt_take;

    ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (pc_advance),
        .load    (pc_load),
        .target  (redirect_pc),
        .pc      (pc)
    );

    assign imem_req_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= NOP_INST;
            inst_pc        <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        drop           <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // A response that is stale, or goes stale this cycle, is discarded.
                        if (drop || redirect_valid) begin
                            drop           <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= OUT;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (halt_take) begin
                            state <= HALT;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        inst_valid     <= 1'b0;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IFU_EBREAK_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (halt_take) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with scoreboarded deliveries
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        halted;

    ifu_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } fetch_t;

    fetch_t      exp_q[$];
    fetch_t      obs_q[$];
    logic [63:0] req_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rsp_delay = 1;
    int          cnt;
    int          overlap = 0;
    logic [31:0] pend_word;
    logic [63:0] special_addr = '1;
    logic [31:0] special_word = '0;

    function automatic logic [31:0] mem_at(input logic [63:0] a);
        if (a == special_addr) return special_word;
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // Memory model: one response per accepted request, rsp_delay cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            cnt            <= 0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= pend_word;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                req_q.push_back(imem_req_addr);
                if (cnt != 0) overlap <= overlap + 1;
                if (rsp_delay <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_at(imem_req_addr);
                end else begin
                    cnt       <= rsp_delay - 1;
                    pend_word <= mem_at(imem_req_addr);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && inst_valid && inst_ready) obs_q.push_back(fetch_t'({inst_pc, inst}));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        rsp_delay      = 1;
        special_addr   = '1;
        step();
        step();
        req_q.delete();
        obs_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        for (int i = 0; i < 60 && obs_q.size() < n; i++) step();
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_req(input int n, output bit ok);
        for (int i = 0; i < 60 && req_q.size() < n; i++) step();
        ok = (req_q.size() >= n);
    endtask

    task automatic wait_inst_valid(output bit ok);
        for (int i = 0; i < 60 && inst_valid !== 1'b1; i++) step();
        ok = (inst_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0000_0013 || inst_pc !== RST_PC || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: req_valid=%b addr=%h inst_valid=%b inst=%h inst_pc=%h halted=%b, expected 0 %h 0 00000013 %h 0",
                     imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted, RST_PC, RST_PC);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_req: req_valid=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        bit     ok;
        int     lat;
        fetch_t e, f;
        do_reset();
        special_addr   = RST_PC;
        special_word   = 32'h0000_0093;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_q.push_back(fetch_t'({RST_PC, 32'h0000_0093}));
        exp_q.push_back(fetch_t'({RST_PC + 64'd4, mem_at(RST_PC + 64'd4)}));
        for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) step();
        lat = 0;
        while (inst_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL basic_latency: inst_valid after %0d cycles in REQ, expected 2", lat);
        end
        wait_obs(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_deliveries: got %0d, expected 2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                f = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (f !== e) begin
                    n_fail++;
                    $display("FAIL basic_inst%0d: got pc=%h inst=%h, expected pc=%h inst=%h", k, f.pc, f.word, e.pc, e.word);
                end
            end
            n_checks++;
            if (req_q[0] !== RST_PC || req_q[1] !== RST_PC + 64'd4) begin
                n_fail++;
                $display("FAIL basic_req_addr: got %h %h, expected %h %h", req_q[0], req_q[1], RST_PC, RST_PC + 64'd4);
            end
        end
        imem_req_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit     ok;
        fetch_t e, f;
        do_reset();
        special_addr   = RST_PC;
        special_word   = 32'h0000_0093;
        imem_req_ready = 1'b1;
        exp_q.push_back(fetch_t'({RST_PC, 32'h0000_0093}));
        wait_inst_valid(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_inst_valid: inst_valid=%b, expected 1", inst_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0000_0093 || inst_pc !== RST_PC ||
                imem_req_valid !== 1'b0 || req_q.size() != 1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: inst_valid=%b inst=%h pc=%h req_valid=%b reqs=%0d, expected 1 00000093 %h 0 1",
                         k, inst_valid, inst, inst_pc, imem_req_valid, req_q.size(), RST_PC);
            end
        end
        inst_ready = 1'b1;
        wait_req(2, ok);
        n_checks++;
        if (!ok || req_q[1] !== RST_PC + 64'd4) begin
            n_fail++;
            $display("FAIL stall_next_req: reqs=%0d addr=%h, expected 2 %h", req_q.size(), ok ? req_q[1] : 64'h0, RST_PC + 64'd4);
        end
        wait_obs(1, ok);
        if (ok) begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f !== e) begin
                n_fail++;
                $display("FAIL stall_deliver: got pc=%h inst=%h, expected pc=%h inst=%h", f.pc, f.word, e.pc, e.word);
            end
        end
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bit     ok;
        fetch_t e, f;
        do_reset();
        special_addr   = RST_PC;
        special_word   = 32'hDEAD_BEEF;
        rsp_delay      = 3;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_req(1, ok);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        step();
        redirect_valid = 1'b0;
        exp_q.push_back(fetch_t'({64'h8000_0100, mem_at(64'h8000_0100)}));
        wait_req(2, ok);
        n_checks++;
        if (!ok || req_q[1] !== 64'h8000_0100) begin
            n_fail++;
            $display("FAIL redir_wait_addr: reqs=%0d addr=%h, expected 2 0000000080000100", req_q.size(), ok ? req_q[1] : 64'h0);
        end
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL redir_wait_deliver: got %0d deliveries, expected 1", obs_q.size());
        end else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            if (f !== e) begin
                n_fail++;
                $display("FAIL redir_wait_inst: got pc=%h inst=%h, expected pc=%h inst=%h", f.pc, f.word, e.pc, e.word);
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL one_outstanding: %0d overlapping requests, expected 0", overlap);
        end
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
    endtask

    task automatic test_redirect_handshake();
        bit     ok;
        fetch_t e, f;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_q.push_back(fetch_t'({RST_PC, mem_at(RST_PC)}));
        exp_q.push_back(fetch_t'({64'h8000_0200, mem_at(64'h8000_0200)}));
        wait_inst_valid(ok);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        wait_obs(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL redir_hs_deliveries: got %0d, expected 2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                f = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (f !== e) begin
                    n_fail++;
                    $display("FAIL redir_hs_inst%0d: got pc=%h inst=%h, expected pc=%h inst=%h", k, f.pc, f.word, e.pc, e.word);
                end
            end
            n_checks++;
            if (req_q[1] !== 64'h8000_0200) begin
                n_fail++;
                $display("FAIL redir_hs_addr: got %h, expected 0000000080000200", req_q[1]);
            end
        end
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
    endtask

    task automatic test_wrap();
        bit     ok;
        fetch_t e, f;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFD;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC || req_q.size() != 0) begin
            n_fail++;
            $display("FAIL redir_req_pending: req_valid=%b addr=%h reqs=%0d, expected 1 fffffffffffffffc 0",
                     imem_req_valid, imem_req_addr, req_q.size());
        end
        imem_req_ready = 1'b1;
        exp_q.push_back(fetch_t'({64'hFFFF_FFFF_FFFF_FFFC, mem_at(64'hFFFF_FFFF_FFFF_FFFC)}));
        exp_q.push_back(fetch_t'({64'h0, mem_at(64'h0)}));
        wait_obs(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_deliveries: got %0d, expected 2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                f = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (f !== e) begin
                    n_fail++;
                    $display("FAIL wrap_inst%0d: got pc=%h inst=%h, expected pc=%h inst=%h", k, f.pc, f.word, e.pc, e.word);
                end
            end
            n_checks++;
            if (req_q[1] !== 64'h0) begin
                n_fail++;
                $display("FAIL wrap_addr: got %h, expected 0000000000000000", req_q[1]);
            end
        end
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
    endtask

    task automatic test_ebreak();
        bit     ok;
        int     highs;
        fetch_t e, f;
        do_reset();
        special_addr   = RST_PC;
        special_word   = 32'h0010_0073;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_q.push_back(fetch_t'({RST_PC, 32'h0010_0073}));
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ebreak_deliver: got %0d deliveries, expected 1", obs_q.size());
        end else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            if (f !== e) begin
                n_fail++;
                $display("FAIL ebreak_inst: got pc=%h inst=%h, expected pc=%h inst=%h", f.pc, f.word, e.pc, e.word);
            end
        end
`ifdef IFU_EBREAK_HALT_EN
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: halted=%b, expected 1", halted);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0400;
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (imem_req_valid !== 1'b0) highs++;
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (highs != 0 || req_q.size() != 1 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_hold: req_valid high %0d cycles reqs=%0d halted=%b, expected 0 1 1", highs, req_q.size(), halted);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%b, expected 0", halted);
        end
        rst_n = 1'b1;
`else
        highs = 0;
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL ebreak_no_halt: halted=%b, expected 0", halted);
        end
        wait_req(2, ok);
        n_checks++;
        if (!ok || req_q[1] !== RST_PC + 64'd4 || highs != 0) begin
            n_fail++;
            $display("FAIL ebreak_continue: reqs=%0d addr=%h, expected 2 %h", req_q.size(), ok ? req_q[1] : 64'h0, RST_PC + 64'd4);
        end
`endif
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_wrap();
        test_ebreak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
